rgb_pwm_fader: RTL and testbench

RGB_PWM_FADER -- requirements
Module: rgb_pwm_fader

---
 rtl/rgb_pwm_pkg.sv | 35 +++
 rtl/pwm_fade_channel.sv | 86 ++++++++
 rtl/rgb_pwm_fader.sv | 124 ++++++++++++
 tb/tb_rgb_pwm_fader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pwm_pkg.sv
// Shared constants, types and helpers for the RGB PWM fader.
package rgb_pwm_pkg;

  // Brightness level width and the full-on code.
  localparam int unsigned LEVEL_W = 8;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 8'd255;

  // Default dividers for a 100 MHz clock: ~1 kHz PWM, 256 fade steps in ~1 s.
  localparam int unsigned PWM_DIV_DEFAULT  = 391;
  localparam int unsigned FADE_DIV_DEFAULT = 390_625;

  typedef logic [LEVEL_W-1:0] level_t;

  // Counter width needed to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n > 32'd1) begin
      return $clog2(n);
    end else begin
      return 32'd1;
    end
  endfunction

  // One saturating step of cur toward tgt; equal values stay put.
  // Because tgt is itself a valid level, the result can never wrap.
  function automatic level_t step_toward(input level_t cur, input level_t tgt);
    if (cur < tgt) begin
      return cur + 8'd1;
    end else if (cur > tgt) begin
      return cur - 8'd1;
    end else begin
      return cur;
    end
  endfunction

endpackage

// File: rtl/pwm_fade_channel.sv
// One LED colour channel: target select, level ramp, period-stable duty,
// PWM compare and the output flop.
module pwm_fade_channel
  import rgb_pwm_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               on_i,
  input  logic [LEVEL_W-1:0] max_level_i,
  input  logic [LEVEL_W-1:0] pwm_cnt_i,
  input  logic               fade_tick_i,
  input  logic               period_end_i,
  output logic               pwm_o,
  output logic               diff_o
);

  logic               on_q;
  logic               on_d;
  level_t             level_q;
  level_t             level_d;
  level_t             duty_q;
  level_t             duty_d;
  logic               pwm_q;
  logic               pwm_d;
  level_t             target_s;

  // Target follows the registered on/off input; max_level is taken live.
  always_comb begin
    target_s = 8'd0;
    if (on_q) begin
      target_s = max_level_i;
    end else begin
      target_s = 8'd0;
    end
  end

  // Next-state logic: input capture, one ramp step per fade tick,
  // duty reload only at the period boundary, and the PWM compare.
  always_comb begin
    on_d    = on_i;
    level_d = level_q;
    duty_d  = duty_q;
    pwm_d   = 1'b0;

    if (fade_tick_i) begin
      level_d = step_toward(level_q, target_s);
    end else begin
      level_d = level_q;
    end

    // duty takes the current (pre-step) level, so a coincident fade tick
    // shows up one period later rather than mid-period.
    if (period_end_i) begin
      duty_d = level_q;
    end else begin
      duty_d = duty_q;
    end

    // Full scale is forced high so the 255 code gives a solid-on LED
    // instead of 255/256 duty; duty 0 never satisfies cnt < duty.
    if (duty_q == LEVEL_MAX) begin
      pwm_d = 1'b1;
    end else begin
      pwm_d = (pwm_cnt_i < duty_q);
    end
  end

  // Channel state registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      on_q    <= 1'b0;
      level_q <= 8'd0;
      duty_q  <= 8'd0;
      pwm_q   <= 1'b0;
    end else begin
      on_q    <= on_d;
      level_q <= level_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_o  = pwm_q;
  assign diff_o = (level_q != target_s);

endmodule

// File: rtl/rgb_pwm_fader.sv
// RGB LED fader: shared PWM prescaler, PWM counter and fade divider driving
// three identical fade/PWM channels, plus a registered busy flag.
module rgb_pwm_fader
  import rgb_pwm_pkg::*;
#(
  parameter int unsigned PWM_DIV  = PWM_DIV_DEFAULT,
  parameter int unsigned FADE_DIV = FADE_DIV_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               r_in,
  input  logic               g_in,
  input  logic               b_in,
  input  logic [LEVEL_W-1:0] max_level,
  output logic               r_pwm,
  output logic               g_pwm,
  output logic               b_pwm,
  output logic               busy
);

  localparam int unsigned PRE_W  = cnt_width(PWM_DIV);
  localparam int unsigned FADE_W = cnt_width(FADE_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PWM_DIV - 32'd1);
  localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_DIV - 32'd1);

  logic [PRE_W-1:0]  pre_q;
  logic [PRE_W-1:0]  pre_d;
  level_t            pwm_cnt_q;
  level_t            pwm_cnt_d;
  logic [FADE_W-1:0] fade_q;
  logic [FADE_W-1:0] fade_d;
  logic              busy_q;
  logic              busy_d;

  logic              pwm_tick_s;
  logic              fade_tick_s;
  logic              period_end_s;
  logic              diff_r_s;
  logic              diff_g_s;
  logic              diff_b_s;

  // Tick strobes are decoded from the counters' wrap values.
  always_comb begin
    pwm_tick_s   = (pre_q == PRE_LAST);
    fade_tick_s  = (fade_q == FADE_LAST);
    period_end_s = pwm_tick_s && (pwm_cnt_q == LEVEL_MAX);
  end

  // Next-state logic for the shared timebase and the busy flag.
  always_comb begin
    pre_d     = pre_q;
    pwm_cnt_d = pwm_cnt_q;
    fade_d    = fade_q;
    busy_d    = diff_r_s | diff_g_s | diff_b_s;

    if (pwm_tick_s) begin
      pre_d     = '0;
      pwm_cnt_d = pwm_cnt_q + 8'd1;
    end else begin
      pre_d     = pre_q + PRE_W'(1);
      pwm_cnt_d = pwm_cnt_q;
    end

    if (fade_tick_s) begin
      fade_d = '0;
    end else begin
      fade_d = fade_q + FADE_W'(1);
    end
  end

  // Shared timebase and busy registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      pwm_cnt_q <= 8'd0;
      fade_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      pwm_cnt_q <= pwm_cnt_d;
      fade_q    <= fade_d;
      busy_q    <= busy_d;
    end
  end

  pwm_fade_channel u_ch_r (
    .clk          (clk),
    .rst_n        (rst_n),
    .on_i         (r_in),
    .max_level_i  (max_level),
    .pwm_cnt_i    (pwm_cnt_q),
    .fade_tick_i  (fade_tick_s),
    .period_end_i (period_end_s),
    .pwm_o        (r_pwm),
    .diff_o       (diff_r_s)
  );

  pwm_fade_channel u_ch_g (
    .clk          (clk),
    .rst_n        (rst_n),
    .on_i         (g_in),
    .max_level_i  (max_level),
    .pwm_cnt_i    (pwm_cnt_q),
    .fade_tick_i  (fade_tick_s),
    .period_end_i (period_end_s),
    .pwm_o        (g_pwm),
    .diff_o       (diff_g_s)
  );

  pwm_fade_channel u_ch_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .on_i         (b_in),
    .max_level_i  (max_level),
    .pwm_cnt_i    (pwm_cnt_q),
    .fade_tick_i  (fade_tick_s),
    .period_end_i (period_end_s),
    .pwm_o        (b_pwm),
    .diff_o       (diff_b_s)
  );

  assign busy = busy_q;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Scoreboard bench for rgb_pwm_fader with small dividers.
module tb_rgb_pwm_fader;

  localparam int unsigned PWM_DIV  = 1;
  localparam int unsigned FADE_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       r_in = 1'b0;
  logic       g_in = 1'b0;
  logic       b_in = 1'b0;
  logic [7:0] max_level = 8'd0;
  logic       r_pwm;
  logic       g_pwm;
  logic       b_pwm;
  logic       busy;

  rgb_pwm_fader #(.PWM_DIV(PWM_DIV), .FADE_DIV(FADE_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r_in      (r_in),
    .g_in      (g_in),
    .b_in      (b_in),
    .max_level (max_level),
    .r_pwm     (r_pwm),
    .g_pwm     (g_pwm),
    .b_pwm     (b_pwm),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected state after each clock edge: {busy, r, g, b} and the three levels.
  typedef struct packed {
    logic [3:0] outs;
    logic [7:0] lr;
    logic [7:0] lg;
    logic [7:0] lb;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: edge count since reset release plus per-channel
  // level / duty / captured input, all plain integers.
  int m_k;
  int m_lvl[3];
  int m_duty[3];
  bit m_in[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, expv);
    end
  endtask

  function automatic int lvl(input int c);
    case (c)
      0: return int'(dut.u_ch_r.level_q);
      1: return int'(dut.u_ch_g.level_q);
      2: return int'(dut.u_ch_b.level_q);
      default: return 0;
    endcase
  endfunction

  // One clock edge of the reference model; pushes the expected post-edge view.
  task automatic model_edge();
    int   tgt[3];
    bit   cur_in[3];
    bit   o[3];
    bit   bz;
    int   cnt;
    exp_t e;
    cur_in = '{r_in, g_in, b_in};
    e = '0;
    if (!rst_n) begin
      m_k = 0;
      for (int c = 0; c < 3; c++) begin
        m_lvl[c] = 0; m_duty[c] = 0; m_in[c] = 1'b0;
      end
    end else begin
      m_k++;
      cnt = ((m_k - 1) / int'(PWM_DIV)) % 256;
      bz = 1'b0;
      for (int c = 0; c < 3; c++) begin
        tgt[c] = m_in[c] ? int'(max_level) : 0;
        if (m_lvl[c] != tgt[c]) bz = 1'b1;
        o[c] = (m_duty[c] == 255) || (cnt < m_duty[c]);
      end
      if (m_k % (256 * int'(PWM_DIV)) == 0)
        for (int c = 0; c < 3; c++) m_duty[c] = m_lvl[c];
      if (m_k % int'(FADE_DIV) == 0)
        for (int c = 0; c < 3; c++) begin
          if (m_lvl[c] < tgt[c]) m_lvl[c]++;
          else if (m_lvl[c] > tgt[c]) m_lvl[c]--;
        end
      for (int c = 0; c < 3; c++) m_in[c] = cur_in[c];
      e.outs = {bz, o[0], o[1], o[2]};
      e.lr = 8'(m_lvl[0]); e.lg = 8'(m_lvl[1]); e.lb = 8'(m_lvl[2]);
    end
    exp_q.push_back(e);
  endtask

  // Model runs on every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      model_edge();
    end
  end

  // Monitor: on every falling edge, pop and compare the whole visible state.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", {4'd0, busy, r_pwm, g_pwm, b_pwm, dut.u_ch_r.level_q,
                        dut.u_ch_g.level_q, dut.u_ch_b.level_q},
              {4'd0, e.outs, e.lr, e.lg, e.lb});
      end
    end
  end

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_lvl(input int c, input int v, input int budget, input string name);
    int n = 0;
    while (lvl(c) != v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(lvl(c)), 32'(v));
  endtask

  task automatic wait_cnt(input int v, input int budget, input string name);
    int n = 0;
    while (int'(dut.pwm_cnt_q) != v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(dut.pwm_cnt_q), 32'(v));
  endtask

  task automatic count_high(input int c, output int hi);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      if ((c == 0 && r_pwm) || (c == 2 && b_pwm)) hi++;
      @(negedge clk);
    end
  endtask

  initial begin
    int hi;
    int prev;
    int jumps;
    int n;
    int expd;

    // Reset held: toggle inputs, everything must stay low.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("rst_hold", {28'd0, busy, r_pwm, g_pwm, b_pwm}, 32'd0);
      #1;
      r_in = 1'($urandom); g_in = 1'($urandom); b_in = 1'($urandom);
      max_level = 8'($urandom);
    end
    @(negedge clk); #1;
    r_in = 1'b0; g_in = 1'b0; b_in = 1'b0; max_level = 8'd0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_tick", 32'(dut.pwm_cnt_q), 32'd1);

    // Ramp up on red to full scale.
    @(negedge clk); #1;
    max_level = 8'd255; r_in = 1'b1;
    repeat (2) @(negedge clk);
    check("busy_rise", 32'(busy), 32'd1);
    wait_lvl(0, 255, 1100, "ramp_up_255");
    repeat (2) @(negedge clk);
    check("busy_fall", 32'(busy), 32'd0);

    // Full scale: solid high for a whole period, then solid low at 0.
    repeat (300) @(negedge clk);
    count_high(0, hi);
    check("full_high", 32'(hi), 32'd256);
    #1; max_level = 8'd0;
    wait_lvl(0, 0, 1100, "ramp_down_0");
    repeat (300) @(negedge clk);
    count_high(0, hi);
    check("zero_low", 32'(hi), 32'd0);

    // Reversal on green at level 100.
    #1; r_in = 1'b0; max_level = 8'd255; g_in = 1'b1;
    wait_lvl(1, 100, 500, "rev_reach100");
    #1; g_in = 1'b0;
    n = 0;
    while (lvl(1) == 100 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rev_next", 32'(lvl(1)), 32'd99);
    prev = lvl(1); jumps = 0; n = 0;
    while (lvl(1) != 0 && n < 600) begin
      @(negedge clk);
      if (lvl(1) > prev || prev - lvl(1) > 1) jumps++;
      prev = lvl(1);
      n++;
    end
    check("rev_nojump", 32'(jumps), 32'd0);
    check("rev_end0", 32'(lvl(1)), 32'd0);

    // Mid-period change on blue: duty frozen until the period boundary.
    #1; max_level = 8'd200; b_in = 1'b1;
    wait_lvl(2, 200, 1100, "b_settle");
    wait_cnt(1, 600, "b_align1");
    repeat (2) @(negedge clk);
    wait_cnt(1, 600, "b_align2");
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      if (b_pwm) hi++;
      if (i == 100) begin #1; max_level = 8'd50; end
      @(negedge clk);
    end
    check("midper_same", 32'(hi), 32'd200);
    hi = 0; expd = -1;
    for (int i = 0; i < 256; i++) begin
      if (b_pwm) hi++;
      if (i == 128) expd = m_duty[2];
      @(negedge clk);
    end
    check("midper_next", 32'(hi), 32'(expd));

    // Mid-ramp reset on red at level 50.
    #1; b_in = 1'b0; max_level = 8'd255; r_in = 1'b1;
    wait_lvl(0, 50, 400, "rst_reach50");
    #1; rst_n = 1'b0;
    #1;
    check("rst_outs_now", {28'd0, busy, r_pwm, g_pwm, b_pwm}, 32'd0);
    check("rst_lvl_now", 32'(lvl(0)), 32'd0);
    repeat (5) @(negedge clk);
    #1; rst_n = 1'b1;
    n = 0;
    while (lvl(0) == 0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("restart_from0", 32'(lvl(0)), 32'd1);

    // Randomised phase: sparse random input / max_level changes.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0: r_in = ~r_in;
          1: g_in = ~g_in;
          2: b_in = ~b_in;
          default: max_level = 8'($urandom);
        endcase
      end
    end
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
